// File: rtl/soc.sv
// soc: single-cycle RV64I subset core with a 4096 x 32-bit instruction ROM.
//   clk  rising-edge system clock
//   rst  asynchronous active-high reset (clears PC and the register file)
// There are no other ports. The ROM is loaded and state is observed through the hierarchy:
// rom_inst.rom_mem, riscv_inst.pc, riscv_inst.regs_inst.regs.

// rom: instruction memory, combinational read, no reset and no write port.
//   addr  word address
//   data  instruction word at addr
module rom (
  input  logic [11:0] addr,
  output logic [31:0] data
);
  logic [31:0] rom_mem [0:4095];

  assign data = rom_mem[addr];
endmodule

// regfile: 32 x 64-bit registers, two combinational read ports, one write port.
//   clk, rst        clock and asynchronous reset (clears all registers)
//   ra1/ra2, rd1/rd2 read addresses and data; x0 always reads 0
//   we, wa, wd       write enable, address and data; writes to x0 are dropped
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [63:0] rd1,
  output logic [63:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [63:0] wd
);
  logic [63:0] regs [0:31];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  assign rd1 = (ra1 == 5'd0) ? 64'd0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? 64'd0 : regs[ra2];
endmodule

// riscv: fetch/decode/execute/writeback in one cycle.
//   clk, rst   clock and asynchronous reset
//   imem_addr  ROM word address (pc[13:2])
//   instr      fetched instruction
module riscv (
  input  logic        clk,
  input  logic        rst,
  output logic [11:0] imem_addr,
  input  logic [31:0] instr
);
  localparam logic [6:0] OpReg   = 7'b0110011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpBr    = 7'b1100011;

  logic [63:0] pc, pc_next, pc_plus4;
  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [63:0] imm_i, imm_u, imm_b, imm_j;
  logic [63:0] rs1_val, rs2_val, wd;
  logic        we, br_taken, imm_ok, imm_alt;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign f7     = instr[31:25];

  assign imm_i = {{52{instr[31]}}, instr[31:20]};
  assign imm_u = {{32{instr[31]}}, instr[31:12], 12'd0};
  assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  assign imem_addr = pc[13:2];
  assign pc_plus4  = pc + 64'd4;

  regfile regs_inst (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1),
    .ra2 (rs2),
    .rd1 (rs1_val),
    .rd2 (rs2_val),
    .we  (we),
    .wa  (rd),
    .wd  (wd)
  );

  function automatic logic [63:0] alu(input logic [2:0] fn, input logic alt,
                                      input logic [63:0] a, input logic [63:0] b);
    logic [63:0] sra_res;
    // Kept as a separate assignment so the shift stays arithmetic.
    sra_res = $signed(a) >>> b[5:0];
    case (fn)
      3'b000:  alu = alt ? (a - b) : (a + b);
      3'b001:  alu = a << b[5:0];
      3'b010:  alu = {63'd0, $signed(a) < $signed(b)};
      3'b011:  alu = {63'd0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? sra_res : (a >> b[5:0]);
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  always_comb begin
    br_taken = 1'b0;
    case (f3)
      3'b000:  br_taken = (rs1_val == rs2_val);
      3'b001:  br_taken = (rs1_val != rs2_val);
      3'b100:  br_taken = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_taken = (rs1_val < rs2_val);
      3'b111:  br_taken = (rs1_val >= rs2_val);
      default: br_taken = 1'b0;
    endcase
  end

  // Immediate shifts carry funct6 in imm[11:6]; only SRAI may set bit 30.
  always_comb begin
    imm_ok  = 1'b1;
    imm_alt = 1'b0;
    if (f3 == 3'b001) begin
      imm_ok = (instr[31:26] == 6'b000000);
    end else if (f3 == 3'b101) begin
      imm_ok  = (instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000);
      imm_alt = instr[30];
    end
  end

  always_comb begin
    we      = 1'b0;
    wd      = 64'd0;
    pc_next = pc_plus4;
    case (opcode)
      OpReg: begin
        if ((f7 == 7'b0000000) ||
            ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)))) begin
          we = 1'b1;
          wd = alu(f3, f7[5], rs1_val, rs2_val);
        end
      end
      OpImm: begin
        if (imm_ok) begin
          we = 1'b1;
          wd = alu(f3, imm_alt, rs1_val, imm_i);
        end
      end
      OpLui: begin
        we = 1'b1;
        wd = imm_u;
      end
      OpAuipc: begin
        we = 1'b1;
        wd = pc + imm_u;
      end
      OpJal: begin
        we      = 1'b1;
        wd      = pc_plus4;
        pc_next = pc + imm_j;
      end
      OpJalr: begin
        if (f3 == 3'b000) begin
          we      = 1'b1;
          wd      = pc_plus4;
          pc_next = (rs1_val + imm_i) & ~64'd1;
        end
      end
      OpBr: begin
        if (br_taken) pc_next = pc + imm_b;
      end
      default: ;  // unsupported: NOP
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= 64'd0;
    else     pc <= pc_next;
  end
endmodule

module soc (
  input logic clk,
  input logic rst
);
  logic [11:0] imem_addr;
  logic [31:0] instr;

  rom rom_inst (
    .addr (imem_addr),
    .data (instr)
  );

  riscv riscv_inst (
    .clk       (clk),
    .rst       (rst),
    .imem_addr (imem_addr),
    .instr     (instr)
  );
endmodule

// File: tb/tb_soc.sv
// Directed bench for soc: loads small programs into the ROM through the hierarchy and checks
// registers and PC against hand-computed values.
module tb_soc;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  soc dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_op(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] i_op(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd,
                                       input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] b_op(input logic [12:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  function automatic logic [31:0] j_op(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  function automatic logic [31:0] u_op(input logic [19:0] imm, input logic [4:0] rd,
                                       input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  // Hold reset and fill the ROM with ADDI x0,x0,0.
  task automatic begin_load();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4096; i++) dut.rom_inst.rom_mem[12'(i)] = 32'h0000_0013;
  endtask

  task automatic put(input int addr, input logic [31:0] w);
    dut.rom_inst.rom_mem[12'(addr / 4)] = w;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_add_chain();
    put(0, i_op(12'd5, 5'd0, 3'd0, 5'd27, 7'h13));
    put(4, i_op(12'd7, 5'd0, 3'd0, 5'd28, 7'h13));
    put(8, r_op(7'h00, 5'd28, 5'd27, 3'd0, 5'd29));
  endtask

  task automatic test_reset();
    begin_load();
    put(0, i_op(12'd5, 5'd0, 3'd0, 5'd27, 7'h13));
    step(3);
    checks++;
    if (dut.riscv_inst.pc !== 64'd0) begin
      failures++;
      $display("FAIL reset_pc got %h want %h", dut.riscv_inst.pc, 64'd0);
    end
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (dut.riscv_inst.regs_inst.regs[5'(i)] !== 64'd0) begin
        failures++;
        $display("FAIL reset_x%0d got %h want 0", i, dut.riscv_inst.regs_inst.regs[5'(i)]);
      end
    end
  endtask

  task automatic test_add_chain();
    logic [4:0]  ri [3] = '{5'd27, 5'd28, 5'd29};
    logic [63:0] ev [3] = '{64'd5, 64'd7, 64'd12};
    begin_load();
    load_add_chain();
    release_rst();
    step(3);
    foreach (ri[k]) begin
      checks++;
      if (dut.riscv_inst.regs_inst.regs[ri[k]] !== ev[k]) begin
        failures++;
        $display("FAIL add_chain x%0d got %h want %h", ri[k],
                 dut.riscv_inst.regs_inst.regs[ri[k]], ev[k]);
      end
    end
  endtask

  task automatic test_sub_overflow();
    logic [4:0]  ri [3] = '{5'd27, 5'd28, 5'd29};
    logic [63:0] ev [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1};
    begin_load();
    put(0, i_op(12'hFFF, 5'd0, 3'd0, 5'd27, 7'h13));
    put(4, r_op(7'h00, 5'd27, 5'd27, 3'd0, 5'd28));
    put(8, r_op(7'h20, 5'd27, 5'd0, 3'd0, 5'd29));
    release_rst();
    step(3);
    foreach (ri[k]) begin
      checks++;
      if (dut.riscv_inst.regs_inst.regs[ri[k]] !== ev[k]) begin
        failures++;
        $display("FAIL sub_overflow x%0d got %h want %h", ri[k],
                 dut.riscv_inst.regs_inst.regs[ri[k]], ev[k]);
      end
    end
  endtask

  task automatic test_x0();
    begin_load();
    put(0, i_op(12'd9, 5'd0, 3'd0, 5'd0, 7'h13));
    put(4, r_op(7'h00, 5'd0, 5'd0, 3'd0, 5'd27));
    release_rst();
    step(2);
    checks++;
    if (dut.riscv_inst.regs_inst.rd1 !== 64'd0) begin
      failures++;
      $display("FAIL x0_read got %h want 0", dut.riscv_inst.regs_inst.rd1);
    end
    checks++;
    if (dut.riscv_inst.regs_inst.regs[27] !== 64'd0) begin
      failures++;
      $display("FAIL x0_add x27 got %h want 0", dut.riscv_inst.regs_inst.regs[27]);
    end
  endtask

  task automatic test_branch_loop();
    begin_load();
    put(0,  i_op(12'd3, 5'd0, 3'd0, 5'd27, 7'h13));
    put(4,  i_op(12'd1, 5'd28, 3'd0, 5'd28, 7'h13));
    put(8,  b_op(13'h1FFC, 5'd27, 5'd28, 3'b001));
    put(12, j_op(21'd0, 5'd0));  // self-loop parks the PC at 0xC
    release_rst();
    step(8);
    checks++;
    if (dut.riscv_inst.regs_inst.regs[28] !== 64'd3) begin
      failures++;
      $display("FAIL branch_loop x28 got %h want %h", dut.riscv_inst.regs_inst.regs[28], 64'd3);
    end
    checks++;
    if (dut.riscv_inst.pc !== 64'hC) begin
      failures++;
      $display("FAIL branch_loop pc got %h want %h", dut.riscv_inst.pc, 64'hC);
    end
  endtask

  task automatic test_jal();
    begin_load();
    put(0, j_op(21'd8, 5'd29));
    put(4, i_op(12'd1, 5'd0, 3'd0, 5'd27, 7'h13));
    release_rst();
    step(1);
    checks++;
    if (dut.riscv_inst.regs_inst.regs[29] !== 64'd4) begin
      failures++;
      $display("FAIL jal x29 got %h want %h", dut.riscv_inst.regs_inst.regs[29], 64'd4);
    end
    checks++;
    if (dut.riscv_inst.pc !== 64'd8) begin
      failures++;
      $display("FAIL jal pc got %h want %h", dut.riscv_inst.pc, 64'd8);
    end
    step(1);
    checks++;
    if (dut.riscv_inst.regs_inst.regs[27] !== 64'd0) begin
      failures++;
      $display("FAIL jal_skip x27 got %h want 0", dut.riscv_inst.regs_inst.regs[27]);
    end
  endtask

  task automatic test_alu_misc();
    logic [4:0]  ri [21] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                             5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd18,
                             5'd19, 5'd20, 5'd21};
    logic [63:0] ev [21] = '{64'hFFFF_FFFF_FFFF_FFF8, 64'd3, 64'd1, 64'd0,
                             64'hFFFF_FFFF_FFFF_FFFF, 64'h1FFF_FFFF_FFFF_FFFF, 64'd24,
                             64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0,
                             64'h0000_0300_0000_0000, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1,
                             64'h0000_0000_1234_5000, 64'hFFFF_FFFF_8000_0000, 64'h103C,
                             64'd0, 64'h48, 64'd0, 64'd0, 64'd0};
    begin_load();
    put(32'h00, i_op(12'hFF8, 5'd0, 3'd0, 5'd1, 7'h13));       // addi x1,x0,-8
    put(32'h04, i_op(12'd3, 5'd0, 3'd0, 5'd2, 7'h13));         // addi x2,x0,3
    put(32'h08, r_op(7'h00, 5'd2, 5'd1, 3'b010, 5'd3));        // slt
    put(32'h0C, r_op(7'h00, 5'd2, 5'd1, 3'b011, 5'd4));        // sltu
    put(32'h10, r_op(7'h20, 5'd2, 5'd1, 3'b101, 5'd5));        // sra
    put(32'h14, r_op(7'h00, 5'd2, 5'd1, 3'b101, 5'd6));        // srl
    put(32'h18, r_op(7'h00, 5'd2, 5'd2, 3'b001, 5'd7));        // sll
    put(32'h1C, r_op(7'h00, 5'd2, 5'd1, 3'b100, 5'd8));        // xor
    put(32'h20, r_op(7'h00, 5'd2, 5'd1, 3'b110, 5'd9));        // or
    put(32'h24, r_op(7'h00, 5'd2, 5'd1, 3'b111, 5'd10));       // and
    put(32'h28, i_op(12'h028, 5'd2, 3'b001, 5'd11, 7'h13));    // slli x11,x2,40
    put(32'h2C, i_op(12'h401, 5'd1, 3'b101, 5'd12, 7'h13));    // srai x12,x1,1
    put(32'h30, i_op(12'hFFF, 5'd2, 3'b011, 5'd13, 7'h13));    // sltiu x13,x2,-1
    put(32'h34, u_op(20'h12345, 5'd14, 7'h37));                // lui
    put(32'h38, u_op(20'h80000, 5'd15, 7'h37));                // lui, sign-extended
    put(32'h3C, u_op(20'h00001, 5'd16, 7'h17));                // auipc
    put(32'h40, i_op(12'd0, 5'd0, 3'b011, 5'd17, 7'h03));      // ld -> NOP
    put(32'h44, i_op(12'h04D, 5'd2, 3'b000, 5'd18, 7'h67));    // jalr x18,77(x2) -> 0x50
    put(32'h48, i_op(12'd1, 5'd0, 3'd0, 5'd19, 7'h13));
    put(32'h4C, i_op(12'd1, 5'd0, 3'd0, 5'd19, 7'h13));
    put(32'h50, b_op(13'd8, 5'd2, 5'd1, 3'b100));              // blt taken
    put(32'h54, i_op(12'd1, 5'd0, 3'd0, 5'd20, 7'h13));
    put(32'h58, b_op(13'd8, 5'd2, 5'd1, 3'b111));              // bgeu taken
    put(32'h5C, i_op(12'd1, 5'd0, 3'd0, 5'd21, 7'h13));
    put(32'h60, j_op(21'd0, 5'd0));                            // halt
    release_rst();
    step(22);
    foreach (ri[k]) begin
      checks++;
      if (dut.riscv_inst.regs_inst.regs[ri[k]] !== ev[k]) begin
        failures++;
        $display("FAIL alu_misc x%0d got %h want %h", ri[k],
                 dut.riscv_inst.regs_inst.regs[ri[k]], ev[k]);
      end
    end
    checks++;
    if (dut.riscv_inst.pc !== 64'h60) begin
      failures++;
      $display("FAIL alu_misc pc got %h want %h", dut.riscv_inst.pc, 64'h60);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0]  ri [3] = '{5'd27, 5'd28, 5'd29};
    logic [63:0] ev [3] = '{64'd5, 64'd7, 64'd12};
    begin_load();
    load_add_chain();
    release_rst();
    step(2);
    checks++;
    if (dut.riscv_inst.regs_inst.regs[28] !== 64'd7) begin
      failures++;
      $display("FAIL async_pre x28 got %h want %h", dut.riscv_inst.regs_inst.regs[28], 64'd7);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    foreach (ri[k]) begin
      checks++;
      if (dut.riscv_inst.regs_inst.regs[ri[k]] !== 64'd0) begin
        failures++;
        $display("FAIL async_clear x%0d got %h want 0", ri[k],
                 dut.riscv_inst.regs_inst.regs[ri[k]]);
      end
    end
    checks++;
    if (dut.riscv_inst.pc !== 64'd0) begin
      failures++;
      $display("FAIL async_clear pc got %h want 0", dut.riscv_inst.pc);
    end
    #2;
    rst = 1'b0;
    step(3);
    foreach (ri[k]) begin
      checks++;
      if (dut.riscv_inst.regs_inst.regs[ri[k]] !== ev[k]) begin
        failures++;
        $display("FAIL async_rerun x%0d got %h want %h", ri[k],
                 dut.riscv_inst.regs_inst.regs[ri[k]], ev[k]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    test_reset();
    test_add_chain();
    test_sub_overflow();
    test_x0();
    test_branch_loop();
    test_jal();
    test_alu_misc();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/soc.md
SOC -- requirements
Module: soc

Interface
REQ-001 The module SHALL have no parameters; ROM depth is fixed at 4096 x 32-bit words and register width at 64 bits.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high; while high, all state is held at reset values.
REQ-004 The module SHALL have no other ports; results are observed only through internal hierarchy.

Function
REQ-005 Hierarchy SHALL be fixed as follows, for bench loading and probing:
- instance rom_inst holds array rom_mem[0:4095] of 32-bit words, with no reset and no write port.
- instance riscv_inst contains instance regs_inst, which holds array regs[0:31] of 64-bit registers.
REQ-006 The core SHALL be a single-cycle RV64I subset processor, one instruction retired per clk rising edge while rst is low.
REQ-007 The 64-bit PC SHALL reset to 0x0.
- Fetch is combinational: instruction = rom_mem[pc[13:2]].
- PC bits above 13 are ignored, so fetch wraps modulo 16 KiB.
REQ-008 Supported instructions:
- OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
- OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI, with 6-bit shamt.
- LUI, AUIPC, JAL, JALR.
- BEQ, BNE, BLT, BGE, BLTU, BGEU.
REQ-009 Arithmetic rules:
- Arithmetic is 64-bit two's complement; overflow wraps silently.
- Immediates are sign-extended to 64 bits.
- Shift amount is rs2[5:0] or imm[5:0].
REQ-010 SLT/SLTI SHALL compare signed and SLTU/SLTIU unsigned; the result is 1 or 0, zero-extended.
REQ-011 Next-PC selection:
- Taken branch: pc+imm.
- JAL: pc+imm.
- JALR: (rs1+imm) with bit 0 cleared.
- Otherwise: pc+4.
- JAL and JALR write pc+4 to rd.
REQ-012 Register file:
- Two combinational read ports and one write port, written at the rising edge.
- Writes to x0 are discarded and reads of x0 return 0.
- A read in the same cycle as a write to the same register returns the old value.
REQ-013 Any unsupported opcode, including loads, stores and system instructions, SHALL execute as a NOP: no register write, PC advances by 4.
REQ-014 No traps, interrupts, memory data port, or misalignment exceptions SHALL exist.

Reset
REQ-015 Asserting rst SHALL immediately set PC=0 and regs[0..31]=0, asynchronously to clk.
REQ-016 rom_mem SHALL NOT be affected by rst.
REQ-017 If rst is asserted mid-program, execution SHALL restart from address 0 on the first rising edge after rst deasserts, with all registers zero.
REQ-018 During rst, no register write SHALL occur, even with a valid instruction at ROM[0].

Verification
REQ-019 ADD chain:
- ROM = addi x27,x0,5 ; addi x28,x0,7 ; add x29,x27,x28.
- After 3 rising edges post-reset: x27=5, x28=7, x29=12.
REQ-020 SUB and signed overflow:
- addi x27,x0,-1 ; add x28,x27,x27 ; sub x29,x0,x27.
- Result: x27=0xFFFF_FFFF_FFFF_FFFF, x28=-2, x29=1.
REQ-021 x0 immutability: addi x0,x0,9 ; add x27,x0,x0 -> x0 reads 0, x27=0.
REQ-022 Branch loop:
- addi x27,x0,3 ; loop: addi x28,x28,1 ; bne x28,x27,loop.
- Result: x28=3 and PC=0xC after 8 rising edges.
REQ-023 Jump: jal x29,+8 at address 0 -> x29=4, PC=8, and the instruction at 4 is not executed.
REQ-024 Async reset mid-run:
- Run REQ-019 for 2 edges, then pulse rst high between edges.
- Registers read 0 without a clock edge.
- After release, the REQ-019 results reappear after 3 edges.
